// File: rtl/audio_pkg.sv
// Sample type and default widths shared by the synth voice path and the I2S output.
package audio_pkg;

   localparam int DEFAULT_SAMPLE_WIDTH = 24;
   localparam int DEFAULT_SLOT_WIDTH   = 32;

   typedef logic [DEFAULT_SAMPLE_WIDTH-1:0] Sample_t;

endpackage

// File: rtl/bit_clock_divider.sv
// Divides i_Clock down to a 50% duty bit clock and flags the cycle before each edge.
module bit_clock_divider #(
   parameter int CLKS_PER_BCLK_HALF = 4
) (
   input  logic i_Clock,
   input  logic i_Reset,
   output logic o_BitClock,
   output logic o_RiseStrobe,
   output logic o_FallStrobe
);

   localparam int CW = (CLKS_PER_BCLK_HALF > 1) ? $clog2(CLKS_PER_BCLK_HALF) : 1;

   logic [CW-1:0] count_reg;
   logic          bclk_reg;
   logic          terminal;

   assign terminal = (count_reg == CW'(CLKS_PER_BCLK_HALF - 1));

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         count_reg <= '0;
         bclk_reg  <= 1'b0;
      end else if (terminal) begin
         count_reg <= '0;
         bclk_reg  <= ~bclk_reg;
      end else begin
         count_reg <= count_reg + CW'(1);
      end
   end

   // Strobes mark the cycle whose closing edge moves the bit clock.
   assign o_BitClock   = bclk_reg;
   assign o_RiseStrobe = terminal & ~bclk_reg;
   assign o_FallStrobe = terminal & bclk_reg;

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S serialiser: one-entry sample holding register, mono sample sent on both slots.
module i2s_transmitter
   import audio_pkg::*;
#(
   parameter int CLKS_PER_BCLK_HALF = 4,
   parameter int SAMPLE_WIDTH       = DEFAULT_SAMPLE_WIDTH,
   parameter int SLOT_WIDTH         = DEFAULT_SLOT_WIDTH
) (
   input  logic                    i_Clock,
   input  logic                    i_Reset,
   input  logic [SAMPLE_WIDTH-1:0] i_Sample,
   input  logic                    i_SampleValid,
   output logic                    o_SampleReady,
   output logic                    o_BitClock,
   output logic                    o_WordSelect,
   output logic                    o_SerialData,
   output logic                    o_Underrun
);

   localparam int KW = $clog2(2 * SLOT_WIDTH);
   localparam logic [KW-1:0] K_LAST = KW'(2 * SLOT_WIDTH - 1);

   logic                    fall_strobe;
   logic                    unused_rise_strobe;
   logic [KW-1:0]           k_reg, k_next, j_next;
   logic [SAMPLE_WIDTH-1:0] hold_reg, shift_reg, shift_next, shift_out;
   logic                    hold_full_reg, hold_full_next;
   logic                    ready_reg, ws_reg, sd_reg, underrun_reg;
   logic                    frame_load, handshake, bypass, accept, ws_next;

   bit_clock_divider #(
      .CLKS_PER_BCLK_HALF(CLKS_PER_BCLK_HALF)
   ) u_divider (
      .i_Clock      (i_Clock),
      .i_Reset      (i_Reset),
      .o_BitClock   (o_BitClock),
      .o_RiseStrobe (unused_rise_strobe),
      .o_FallStrobe (fall_strobe)
   );

   assign k_next     = (k_reg == K_LAST) ? '0 : k_reg + KW'(1);
   assign j_next     = (k_next >= KW'(SLOT_WIDTH)) ? k_next - KW'(SLOT_WIDTH) : k_next;
   assign ws_next    = (k_next >= KW'(SLOT_WIDTH - 1)) && (k_next <= KW'(2 * SLOT_WIDTH - 2));

   assign frame_load = fall_strobe && (k_reg == K_LAST);
   assign handshake  = i_SampleValid && ready_reg;
   assign bypass     = frame_load && !hold_full_reg && handshake;
   assign accept     = handshake && !bypass;

   always_comb begin
      shift_next = shift_reg;
      if (frame_load) begin
         if (hold_full_reg)
            shift_next = hold_reg;
         else if (bypass)
            shift_next = i_Sample;
         else
            shift_next = '0;
      end
   end

   always_comb begin
      hold_full_next = hold_full_reg;
      if (frame_load && hold_full_reg)
         hold_full_next = 1'b0;
      else if (accept)
         hold_full_next = 1'b1;
   end

   // Shifting left by the slot bit index drops out the padding bits past the sample LSB.
   assign shift_out = shift_next << j_next;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         k_reg         <= K_LAST;
         hold_reg      <= '0;
         hold_full_reg <= 1'b0;
         shift_reg     <= '0;
         ready_reg     <= 1'b0;
         ws_reg        <= 1'b0;
         sd_reg        <= 1'b0;
         underrun_reg  <= 1'b0;
      end else begin
         hold_full_reg <= hold_full_next;
         ready_reg     <= ~hold_full_next;
         underrun_reg  <= frame_load && !hold_full_reg && !bypass;
         if (accept)
            hold_reg <= i_Sample;
         if (fall_strobe) begin
            k_reg     <= k_next;
            shift_reg <= shift_next;
            ws_reg    <= ws_next;
            sd_reg    <= shift_out[SAMPLE_WIDTH-1];
         end
      end
   end

   assign o_SampleReady = ready_reg;
   assign o_WordSelect  = ws_reg;
   assign o_SerialData  = sd_reg;
   assign o_Underrun    = underrun_reg;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench: a frame-level model predicts each I2S frame; a DAC-side monitor decodes and compares.
module tb_i2s_transmitter;
   import audio_pkg::*;

   localparam int H     = 4;
   localparam int SLOT  = 32;
   localparam int LOAD0 = 2 * H;
   localparam int FRAME = 4 * SLOT * H;
   localparam logic [63:0] WS_PATTERN = 64'h0000_0001_FFFF_FFFE;

   logic    clk = 1'b0;
   logic    i_Reset = 1'b1;
   logic    i_SampleValid = 1'b0;
   Sample_t i_Sample = '0;
   logic    o_SampleReady, o_BitClock, o_WordSelect, o_SerialData, o_Underrun;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model state: n counts clock edges since reset was released.
   int      n = 0;
   bit      started = 1'b0;
   bit      held_v = 1'b0;
   Sample_t held_s = '0;
   bit      ready_exp = 1'b0;
   bit      ur_exp = 1'b0;
   bit      consumed = 1'b0;
   bit      hs;
   Sample_t exp_q[$];

   // DAC-side monitor state.
   int          idx = -1;
   bit          prev_ws = 1'b1;
   bit          prev_bclk = 1'b0;
   logic [63:0] got_sd, got_ws;
   Sample_t     exp_s;
   int          frames_seen = 0;

   int L;

   i2s_transmitter #(
      .CLKS_PER_BCLK_HALF(H),
      .SAMPLE_WIDTH      (24),
      .SLOT_WIDTH        (SLOT)
   ) dut (
      .i_Clock       (clk),
      .i_Reset       (i_Reset),
      .i_Sample      (i_Sample),
      .i_SampleValid (i_SampleValid),
      .o_SampleReady (o_SampleReady),
      .o_BitClock    (o_BitClock),
      .o_WordSelect  (o_WordSelect),
      .o_SerialData  (o_SerialData),
      .o_Underrun    (o_Underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, n);
      end
   endtask

   // Model: a frame starts every FRAME edges from edge LOAD0 and carries the held
   // sample, else a sample handed over on that edge, else silence plus underrun.
   initial forever begin
      @(posedge clk);
      consumed = 1'b0;
      if (i_Reset) begin
         started   = 1'b1;
         n         = 0;
         held_v    = 1'b0;
         ready_exp = 1'b0;
         ur_exp    = 1'b0;
         exp_q.delete();
      end else if (started) begin
         n++;
         ur_exp = 1'b0;
         hs     = i_SampleValid && ready_exp;
         if (n >= LOAD0 && (n - LOAD0) % FRAME == 0) begin
            if (held_v) begin
               exp_q.push_back(held_s);
               held_v = 1'b0;
            end else if (hs) begin
               exp_q.push_back(i_Sample);
               consumed = 1'b1;
               hs = 1'b0;
            end else begin
               exp_q.push_back('0);
               ur_exp = 1'b1;
            end
         end
         if (hs) begin
            held_v   = 1'b1;
            held_s   = i_Sample;
            consumed = 1'b1;
         end
         ready_exp = !held_v;
      end
   end

   // Checker and monitor on the inactive edge; frames are decoded on rising BCLK like a DAC.
   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("ready", o_SampleReady, ready_exp);
         chk("bclk", o_BitClock, ((n / H) % 2) != 0);
         chk("underrun", o_Underrun, ur_exp);
         if (n == 0) begin
            chk("ws_reset", o_WordSelect, 0);
            chk("sd_reset", o_SerialData, 0);
            idx = -1;
            prev_ws = 1'b1;
            prev_bclk = 1'b0;
         end else begin
            if (!prev_bclk && o_BitClock) begin
               if (idx >= 0) begin
                  got_sd[63-idx] = o_SerialData;
                  got_ws[63-idx] = o_WordSelect;
                  idx++;
                  if (idx == 64) begin
                     idx = -1;
                     if (exp_q.size() == 0) begin
                        chk("frame_expected", 1, 0);
                     end else begin
                        exp_s = exp_q.pop_front();
                        frames_seen++;
                        chk("frame_sd", got_sd, {exp_s, 8'h00, exp_s, 8'h00});
                        chk("frame_ws", got_ws, WS_PATTERN);
                        $display("frame %0d: sample %h sd %h ws %h", frames_seen, exp_s, got_sd, got_ws);
                     end
                  end
               end
               if (!o_WordSelect && prev_ws)
                  idx = 0;
               prev_ws = o_WordSelect;
            end
            prev_bclk = o_BitClock;
         end
      end
   end

   task automatic wait_n(input int t);
      do @(negedge clk); while (n < t);
   endtask

   task automatic send(input Sample_t s);
      int budget;
      budget = 0;
      @(negedge clk);
      i_SampleValid = 1'b1;
      i_Sample = s;
      forever begin
         @(posedge clk);
         #1;
         if (consumed) break;
         budget++;
         if (budget > 2 * FRAME) begin
            chk("send_timeout", 1, 0);
            break;
         end
      end
      $display("sent %h at edge %0d", s, n);
      i_SampleValid = 1'b0;
      i_Sample = Sample_t'($urandom);
   endtask

   initial begin
      #(20000 * 10);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      i_Reset = 1'b0;

      // Frame at LOAD0 underruns; A5C3F0 rides the next frame.
      wait_n(100);
      send(24'hA5C3F0);

      // Bypass: valid exactly on the load edge with the holding register empty.
      wait_n(LOAD0 + 2 * FRAME - 1);
      i_SampleValid = 1'b1;
      i_Sample = 24'h800000;
      @(posedge clk);
      #1;
      $display("bypass offer 800000 at edge %0d consumed=%0d", n, consumed);
      i_SampleValid = 1'b0;

      // Back-to-back: second waits for the holding register to drain.
      wait_n(LOAD0 + 2 * FRAME + 60);
      send(Sample_t'($urandom));
      send(Sample_t'($urandom));

      // One sample per frame at a random offset within the frame.
      for (int f = 0; f < 8; f++) begin
         wait_n(LOAD0 + 4 * FRAME + f * FRAME + 1 + $urandom_range(0, 400));
         send(Sample_t'($urandom));
      end

      // Reset at k=10 of a frame carrying 7FFFFF while another sample is held.
      wait_n(LOAD0 + 12 * FRAME + 10);
      send(24'h7FFFFF);
      L = LOAD0 + 13 * FRAME;
      wait_n(L + 2);
      send(24'h123456);
      wait_n(L + 83);
      i_Reset = 1'b1;
      @(negedge clk);
      i_Reset = 1'b0;
      $display("mid-frame reset applied");

      wait_n(LOAD0 + FRAME + 20);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
